// File: rtl/sal_rd_resp_buf_if.sv
// Read-return bus bundle: scheduler descriptor post, DFI read data capture and AXI R channel.
// The master modport is the environment side; the slave modport is the buffer itself.
interface sal_rd_resp_buf_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 4
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ID_W-1:0]   cmd_id_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              dfi_rddata_valid_i;
  logic [DATA_W-1:0] dfi_rddata_i;
  logic              r_valid_o;
  logic              r_ready_i;
  logic [ID_W-1:0]   r_id_o;
  logic [DATA_W-1:0] r_data_o;
  logic [1:0]        r_resp_o;
  logic              r_last_o;
  logic              err_o;

  modport master (
    output cmd_valid_i, cmd_id_i, cmd_len_i, dfi_rddata_valid_i, dfi_rddata_i, r_ready_i,
    input  cmd_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o, err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_id_i, cmd_len_i, dfi_rddata_valid_i, dfi_rddata_i, r_ready_i,
    output cmd_ready_o, r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o, err_o
  );
endinterface

// File: rtl/sal_rd_resp_buf.sv
// Read-return buffer: queues read-burst descriptors, captures DFI read beats into a reserved
// data FIFO and replays them as in-order AXI R bursts.
module sal_rd_resp_buf #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  sal_rd_resp_buf_if.slave   bus
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned CW  = AW + 1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } cmd_t;

  logic [DATA_W-1:0] data_mem [DEPTH];
  cmd_t              cmd_mem  [CMD_DEPTH];

  logic [AW:0]       d_wr_ptr, d_rd_ptr;
  logic [CAW:0]      c_wr_ptr, c_rd_ptr;
  logic [CW-1:0]     resv_cnt, exp_cnt;
  logic [LEN_W-1:0]  beat_cnt;
  logic              err_q;

  logic [CW-1:0]     resv_nxt, exp_nxt;
  logic [CW-1:0]     burst_beats, free_space;
  logic              d_empty, c_empty, c_full;
  logic              cmd_ready, cmd_acc;
  logic              r_valid, r_last, r_hs;
  logic              dfi_wr, dfi_stray;
  cmd_t              head;

  // FIFO status and handshake decode
  always_comb begin
    d_empty     = (d_wr_ptr == d_rd_ptr);
    c_empty     = (c_wr_ptr == c_rd_ptr);
    c_full      = (c_wr_ptr[CAW] != c_rd_ptr[CAW]) &&
                  (c_wr_ptr[CAW-1:0] == c_rd_ptr[CAW-1:0]);
    head        = cmd_mem[c_rd_ptr[CAW-1:0]];
    burst_beats = CW'(bus.cmd_len_i) + CW'(1);
    free_space  = CW'(DEPTH) - resv_cnt;
    cmd_ready   = !rst && !c_full && (free_space >= burst_beats);
    cmd_acc     = bus.cmd_valid_i && cmd_ready;
    r_valid     = !c_empty && !d_empty;
    r_last      = r_valid && (beat_cnt == head.len);
    r_hs        = r_valid && bus.r_ready_i;
    dfi_wr      = bus.dfi_rddata_valid_i && (exp_cnt != '0);
    dfi_stray   = bus.dfi_rddata_valid_i && (exp_cnt == '0);
  end

  // Reservation counters: accept adds a whole burst, R handshake / DFI beat remove one each
  always_comb begin
    resv_nxt = resv_cnt;
    exp_nxt  = exp_cnt;
    if (cmd_acc) begin
      resv_nxt = resv_nxt + burst_beats;
      exp_nxt  = exp_nxt + burst_beats;
    end
    if (r_hs) begin
      resv_nxt = resv_nxt - CW'(1);
    end
    if (dfi_wr) begin
      exp_nxt = exp_nxt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_wr_ptr <= '0;
      d_rd_ptr <= '0;
      c_wr_ptr <= '0;
      c_rd_ptr <= '0;
      resv_cnt <= '0;
      exp_cnt  <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      resv_cnt <= resv_nxt;
      exp_cnt  <= exp_nxt;
      if (cmd_acc) begin
        c_wr_ptr <= c_wr_ptr + (CAW+1)'(1);
      end
      if (dfi_wr) begin
        d_wr_ptr <= d_wr_ptr + (AW+1)'(1);
      end
      if (dfi_stray) begin
        err_q <= 1'b1;
      end
      if (r_hs) begin
        d_rd_ptr <= d_rd_ptr + (AW+1)'(1);
        if (r_last) begin
          c_rd_ptr <= c_rd_ptr + (CAW+1)'(1);
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + LEN_W'(1);
        end
      end
    end
  end

  // Storage arrays need no reset: every read is qualified by the pointer-derived valid
  always_ff @(posedge clk) begin
    if (dfi_wr) begin
      data_mem[d_wr_ptr[AW-1:0]] <= bus.dfi_rddata_i;
    end
    if (cmd_acc) begin
      cmd_mem[c_wr_ptr[CAW-1:0]] <= cmd_t'{id: bus.cmd_id_i, len: bus.cmd_len_i};
    end
  end

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.r_valid_o   = r_valid;
  assign bus.r_id_o      = r_valid ? head.id : '0;
  assign bus.r_data_o    = r_valid ? data_mem[d_rd_ptr[AW-1:0]] : '0;
  assign bus.r_resp_o    = 2'b00;
  assign bus.r_last_o    = r_last;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_sal_rd_resp_buf.sv
// Bench for sal_rd_resp_buf: directed table and sequences plus randomized traffic, all
// checked against a queue-based model of descriptor reservation and in-order burst return.
module tb_sal_rd_resp_buf;

  localparam int DATA_W    = 64;
  localparam int ID_W      = 4;
  localparam int LEN_W     = 4;
  localparam int DEPTH     = 16;
  localparam int CMD_DEPTH = 4;

  logic clk;
  logic rst;

  sal_rd_resp_buf_if #(.DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  sal_rd_resp_buf #(
    .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .CMD_DEPTH(CMD_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: outstanding bursts, buffered beats, reserved/expected beat counts
  typedef struct { int id; int len; } mcmd_t;
  mcmd_t       m_cmd[$];
  logic [63:0] m_data[$];
  int          m_resv, m_exp, m_beat;
  bit          m_err;
  int          hs_ids[$];
  bit          hs_lasts[$];

  // Current drive and expectations for this cycle
  bit          c_cv, c_dv, c_rr;
  int          c_id, c_len;
  logic [63:0] c_d;
  bit          e_rv, e_ready, e_last;
  int          e_id;
  logic [63:0] e_data;

  typedef struct {
    bit cv; int id; int len; bit dv; logic [63:0] d; bit rr;
    bit x_ready; bit x_rv; bit x_last; int x_id; logic [63:0] x_data;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmd.delete();
    m_data.delete();
    m_resv = 0;
    m_exp  = 0;
    m_beat = 0;
    m_err  = 0;
  endtask

  task automatic drive(input bit cv, input int id, input int len, input bit dv,
                       input logic [63:0] d, input bit rr);
    c_cv = cv; c_id = id; c_len = len; c_dv = dv; c_d = d; c_rr = rr;
    bus.cmd_valid_i        = cv;
    bus.cmd_id_i           = ID_W'(id);
    bus.cmd_len_i          = LEN_W'(len);
    bus.dfi_rddata_valid_i = dv;
    bus.dfi_rddata_i       = d;
    bus.r_ready_i          = rr;
  endtask

  // Expected outputs follow from the model state and the current descriptor length
  task automatic check_model();
    e_rv    = (m_cmd.size() > 0) && (m_data.size() > 0);
    e_ready = (m_cmd.size() < CMD_DEPTH) && ((DEPTH - m_resv) >= c_len + 1);
    e_last  = e_rv && (m_beat == m_cmd[0].len);
    e_id    = e_rv ? m_cmd[0].id : 0;
    e_data  = e_rv ? m_data[0] : 64'h0;
    chk("r_valid",   64'(bus.r_valid_o),   64'(e_rv));
    chk("cmd_ready", 64'(bus.cmd_ready_o), 64'(e_ready));
    chk("r_last",    64'(bus.r_last_o),    64'(e_last));
    chk("err",       64'(bus.err_o),       64'(m_err));
    chk("r_resp",    64'(bus.r_resp_o),    64'h0);
    if (e_rv) begin
      chk("r_id",   64'(bus.r_id_o), 64'(e_id));
      chk("r_data", bus.r_data_o,    e_data);
    end
  endtask

  task automatic advance();
    int  exp_before;
    bit  acc;
    acc        = c_cv && e_ready;
    exp_before = m_exp;
    @(posedge clk);
    if (e_rv && c_rr) begin
      hs_ids.push_back(m_cmd[0].id);
      hs_lasts.push_back(e_last);
      void'(m_data.pop_front());
      m_resv--;
      if (e_last) begin
        void'(m_cmd.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (acc) begin
      m_cmd.push_back('{id: c_id, len: c_len});
      m_resv += c_len + 1;
      m_exp  += c_len + 1;
    end
    if (c_dv) begin
      if (exp_before > 0) begin
        m_data.push_back(c_d);
        m_exp--;
      end else begin
        m_err = 1;
      end
    end
    #1;
  endtask

  task automatic step(input bit cv, input int id, input int len, input bit dv,
                      input logic [63:0] d, input bit rr);
    drive(cv, id, len, dv, d, rr);
    #1;
    check_model();
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      if (m_cmd.size() == 0 && m_exp == 0) begin
        done = 1;
        break;
      end
      step(0, 0, 0, m_exp > 0, {$urandom, $urandom}, 1);
      advance();
    end
    if (m_cmd.size() == 0 && m_exp == 0) done = 1;
    chk("drain_done", 64'(done), 64'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Test 1 vectors: one 4-beat burst with immediate drain
    tbl[0] = '{1, 3, 3, 0, 64'h0,    1, 1, 0, 0, 0, 64'h0};
    tbl[1] = '{0, 0, 0, 1, 64'hA0,   1, 1, 0, 0, 0, 64'h0};
    tbl[2] = '{0, 0, 0, 1, 64'hA1,   1, 1, 1, 0, 3, 64'hA0};
    tbl[3] = '{0, 0, 0, 1, 64'hA2,   1, 1, 1, 0, 3, 64'hA1};
    tbl[4] = '{0, 0, 0, 1, 64'hA3,   1, 1, 1, 0, 3, 64'hA2};
    tbl[5] = '{0, 0, 0, 0, 64'h0,    1, 1, 1, 1, 3, 64'hA3};
    tbl[6] = '{0, 0, 0, 0, 64'h0,    1, 1, 0, 0, 0, 64'h0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 64'h0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r_valid",   64'(bus.r_valid_o),   64'h0);
    chk("rst_r_last",    64'(bus.r_last_o),    64'h0);
    chk("rst_r_id",      64'(bus.r_id_o),      64'h0);
    chk("rst_r_data",    bus.r_data_o,         64'h0);
    chk("rst_err",       64'(bus.err_o),       64'h0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready_o), 64'h1);
    @(posedge clk);
    #1;

    // Test 1: table-driven single burst
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].cv, tbl[i].id, tbl[i].len, tbl[i].dv, tbl[i].d, tbl[i].rr);
      chk($sformatf("t1_ready_%0d", i), 64'(bus.cmd_ready_o), 64'(tbl[i].x_ready));
      chk($sformatf("t1_valid_%0d", i), 64'(bus.r_valid_o),   64'(tbl[i].x_rv));
      chk($sformatf("t1_last_%0d", i),  64'(bus.r_last_o),    64'(tbl[i].x_last));
      if (tbl[i].x_rv) begin
        chk($sformatf("t1_id_%0d", i),   64'(bus.r_id_o), 64'(tbl[i].x_id));
        chk($sformatf("t1_data_%0d", i), bus.r_data_o,    tbl[i].x_data);
      end
      advance();
    end

    // Test 2: back-pressure holds the head beat
    step(1, 1, 1, 0, 64'h0, 0);    advance();
    step(0, 0, 0, 1, 64'hB0, 0);   advance();
    step(0, 0, 0, 1, 64'hB1, 0);   advance();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 64'h0, 0);
      chk("t2_hold_valid", 64'(bus.r_valid_o), 64'h1);
      chk("t2_hold_data",  bus.r_data_o,       64'hB0);
      advance();
    end
    step(0, 0, 0, 0, 64'h0, 1);
    chk("t2_b0_data", bus.r_data_o,       64'hB0);
    chk("t2_b0_last", 64'(bus.r_last_o),  64'h0);
    advance();
    step(0, 0, 0, 0, 64'h0, 1);
    chk("t2_b1_data", bus.r_data_o,       64'hB1);
    chk("t2_b1_last", 64'(bus.r_last_o),  64'h1);
    advance();
    step(0, 0, 15, 0, 64'h0, 0);
    chk("t2_resv_empty", 64'(bus.cmd_ready_o), 64'h1);
    advance();

    // Test 3: full reservation blocks every length until one beat returns
    step(1, 9, 15, 0, 64'h0, 0);   advance();
    step(0, 0, 0, 1, 64'hC0, 0);
    chk("t3_block_len0", 64'(bus.cmd_ready_o), 64'h0);
    advance();
    step(0, 0, 15, 0, 64'h0, 1);
    chk("t3_block_len15", 64'(bus.cmd_ready_o), 64'h0);
    chk("t3_first_valid", 64'(bus.r_valid_o),   64'h1);
    advance();
    step(1, 10, 0, 0, 64'h0, 0);
    chk("t3_free_one", 64'(bus.cmd_ready_o), 64'h1);
    advance();
    drain(200);

    // Test 4: ordering across bursts and descriptor FIFO full
    hs_ids.delete();
    hs_lasts.delete();
    step(1, 2, 0, 0, 64'h0, 0);    advance();
    step(1, 5, 2, 0, 64'h0, 0);    advance();
    step(1, 7, 0, 0, 64'h0, 0);    advance();
    step(1, 8, 0, 0, 64'h0, 0);    advance();
    step(1, 11, 0, 0, 64'h0, 0);
    chk("t4_cmd_full", 64'(bus.cmd_ready_o), 64'h0);
    advance();
    drain(200);
    begin
      int exp_ids[6]  = '{2, 5, 5, 5, 7, 8};
      bit exp_last[6] = '{1, 0, 0, 1, 1, 1};
      chk("t4_beats", 64'(hs_ids.size()), 64'h6);
      for (int i = 0; i < 6 && i < hs_ids.size(); i++) begin
        chk($sformatf("t4_id_%0d", i),   64'(hs_ids[i]),   64'(exp_ids[i]));
        chk($sformatf("t4_last_%0d", i), 64'(hs_lasts[i]), 64'(exp_last[i]));
      end
    end

    // Test 5: stray DFI beat sets the sticky error
    step(0, 0, 0, 1, 64'hDEAD, 1);
    chk("t5_err_before", 64'(bus.err_o), 64'h0);
    advance();
    step(0, 0, 0, 0, 64'h0, 1);
    chk("t5_err_set",   64'(bus.err_o),     64'h1);
    chk("t5_no_valid",  64'(bus.r_valid_o), 64'h0);
    advance();

    // Test 6: asynchronous reset mid-burst discards it
    step(1, 6, 3, 0, 64'h0, 1);    advance();
    step(0, 0, 0, 1, 64'hD0, 1);   advance();
    step(0, 0, 0, 1, 64'hD1, 1);   advance();
    step(0, 0, 0, 1, 64'hD2, 1);   advance();
    drive(0, 0, 0, 0, 64'h0, 1);
    #1;
    chk("t6_pre_valid", 64'(bus.r_valid_o), 64'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.r_valid_o),   64'h0);
    chk("t6_rst_last",  64'(bus.r_last_o),    64'h0);
    chk("t6_rst_id",    64'(bus.r_id_o),      64'h0);
    chk("t6_rst_data",  bus.r_data_o,         64'h0);
    chk("t6_rst_err",   64'(bus.err_o),       64'h0);
    chk("t6_rst_ready", 64'(bus.cmd_ready_o), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 4, 0, 0, 64'h0, 1);    advance();
    step(0, 0, 0, 1, 64'hE0, 1);   advance();
    step(0, 0, 0, 0, 64'h0, 1);
    chk("t6_new_valid", 64'(bus.r_valid_o), 64'h1);
    chk("t6_new_id",    64'(bus.r_id_o),    64'h4);
    chk("t6_new_last",  64'(bus.r_last_o),  64'h1);
    chk("t6_new_data",  bus.r_data_o,       64'hE0);
    advance();
    step(0, 0, 0, 0, 64'h0, 1);
    chk("t6_done", 64'(bus.r_valid_o), 64'h0);
    advance();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit cv, dv, rr;
      int len;
      cv  = ($urandom_range(0, 2) == 0);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      dv  = (m_exp > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 255) == 0);
      rr  = ($urandom_range(0, 3) != 0);
      step(cv, $urandom_range(0, 15), len, dv, {$urandom, $urandom}, rr);
      advance();
    end
    drain(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
